accelbrot_com_ram_fifo_pkt: RTL and testbench

ACCELBROT_COM_RAM_FIFO_PKT -- requirements
Module: accelbrot_com_ram_fifo_pkt

---
 rtl/accelbrot_com_ram_fifo_pkt.sv | 186 ++++++++++++++++++
 tb/tb_accelbrot_com_ram_fifo_pkt.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelbrot_com_ram_fifo_pkt.sv
`timescale 1ns/1ps
// accelbrot_com_ram_fifo_pkt
// Packet-aware FIFO on a simple-dual-port RAM with a RAM_RD_LATENCY-deep
// read pipeline. Writes land speculatively and become readable only when
// committed (on wr_last in packet mode, on every write otherwise). An open
// packet can be dropped with wr_abort.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   flush                synchronous clear of pointers, counts and pipeline
//   wr_valid/wr_ready    write handshake; wr_data, wr_last, wr_abort
//   rd_valid/rd_ready    read handshake; rd_data, rd_last
//   written              committed + uncommitted occupied entries
//   readable             committed words not yet taken by the reader
//   afull, aempty        registered threshold flags
//   pkt_ovf              sticky: an open packet filled the whole FIFO
module accelbrot_com_ram_fifo_pkt #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int RAM_RD_LATENCY = 2,
    parameter int PACKET_MODE    = 1,
    parameter int AFULL_TH       = DEPTH - 4,
    parameter int AEMPTY_TH      = 4,
    parameter int SIZE_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  wr_abort,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [SIZE_WIDTH-1:0] written,
    output logic [SIZE_WIDTH-1:0] readable,
    output logic                  afull,
    output logic                  aempty,
    output logic                  pkt_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam int L  = RAM_RD_LATENCY;
    localparam logic [SIZE_WIDTH-1:0] DEPTH_S  = SIZE_WIDTH'(DEPTH);
    localparam logic [SIZE_WIDTH-1:0] AFULL_S  = SIZE_WIDTH'(AFULL_TH);
    localparam logic [SIZE_WIDTH-1:0] AEMPTY_S = SIZE_WIDTH'(AEMPTY_TH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [EW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wptr, cptr, rptr;
    logic [PW-1:0]         wptr_nxt, cptr_nxt;
    logic [SIZE_WIDTH-1:0] ucnt, navail;
    logic [SIZE_WIDTH-1:0] ucnt_nxt, navail_nxt, written_nxt, readable_nxt, commit_n;
    logic                  ovf_nxt;
    logic [L-1:0]          pv;
    logic [EW-1:0]         pd [L];
    logic                  abort, wr_acc, rd_acc, adv, issue;

    always_comb begin
        abort    = (PACKET_MODE != 0) && wr_abort;
        // A write in the abort cycle is dropped even if handshaken.
        wr_acc   = wr_valid && wr_ready && !abort;
        rd_acc   = rd_valid && rd_ready;
        // The whole read pipeline (RAM enable included) freezes while the
        // output word is held.
        adv      = !(rd_valid && !rd_ready);
        issue    = adv && (navail != '0);
        commit_n = '0;
        ucnt_nxt = ucnt;
        wptr_nxt = wptr;
        cptr_nxt = cptr;
        ovf_nxt  = 1'b0;
        if (PACKET_MODE == 0) begin
            ucnt_nxt = '0;
            if (wr_acc) begin
                commit_n = SIZE_WIDTH'(1);
                wptr_nxt = ptr_inc(wptr);
                cptr_nxt = ptr_inc(wptr);
            end
        end else if (abort) begin
            ucnt_nxt = '0;
            wptr_nxt = cptr;
        end else begin
            if (wr_acc) begin
                wptr_nxt = ptr_inc(wptr);
                if (wr_last) begin
                    // The whole open packet becomes visible at once.
                    commit_n = ucnt + SIZE_WIDTH'(1);
                    ucnt_nxt = '0;
                    cptr_nxt = ptr_inc(wptr);
                end else begin
                    ucnt_nxt = ucnt + SIZE_WIDTH'(1);
                end
            end
            ovf_nxt = pkt_ovf || (ucnt_nxt == DEPTH_S);
        end
        written_nxt  = written + SIZE_WIDTH'(wr_acc) - SIZE_WIDTH'(rd_acc)
                       - (abort ? ucnt : '0);
        readable_nxt = readable + commit_n - SIZE_WIDTH'(rd_acc);
        navail_nxt   = navail + commit_n - SIZE_WIDTH'(issue);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            ucnt     <= '0;
            navail   <= '0;
            written  <= '0;
            readable <= '0;
            wr_ready <= 1'b0;
            pv       <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            afull    <= 1'b0;
            aempty   <= 1'b1;
            pkt_ovf  <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            ucnt     <= '0;
            navail   <= '0;
            written  <= '0;
            readable <= '0;
            wr_ready <= 1'b0;
            pv       <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            afull    <= 1'b0;
            aempty   <= 1'b1;
            pkt_ovf  <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            cptr     <= cptr_nxt;
            ucnt     <= ucnt_nxt;
            navail   <= navail_nxt;
            written  <= written_nxt;
            readable <= readable_nxt;
            wr_ready <= (written_nxt < DEPTH_S);
            afull    <= (written > AFULL_S);
            aempty   <= (readable < AEMPTY_S);
            pkt_ovf  <= ovf_nxt;
            if (issue) begin
                rptr <= ptr_inc(rptr);
            end
            if (adv) begin
                pv[0] <= issue;
                for (int unsigned i = 1; i < L; i++) begin
                    pv[i] <= pv[i-1];
                end
                rd_valid <= pv[L-1];
                if (pv[L-1]) begin
                    rd_last <= pd[L-1][DATA_WIDTH];
                end
            end
        end
    end

    // RAM array and pipeline data carry no reset; their valid bits do.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= {wr_last, wr_data};
        end
        if (adv) begin
            if (issue) begin
                pd[0] <= mem[rptr];
            end
            for (int unsigned i = 1; i < L; i++) begin
                pd[i] <= pd[i-1];
            end
            if (pv[L-1]) begin
                rd_data <= pd[L-1][DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_accelbrot_com_ram_fifo_pkt.sv
`timescale 1ns/1ps
module tb_accelbrot_com_ram_fifo_pkt;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: DEPTH 16, latency 2, packet mode ----------------
    logic        flush_a, wr_valid_a, wr_ready_a, wr_last_a, wr_abort_a;
    logic        rd_ready_a, rd_valid_a, rd_last_a, afull_a, aempty_a, pkt_ovf_a;
    logic [31:0] wr_data_a, rd_data_a;
    logic [4:0]  written_a, readable_a;

    accelbrot_com_ram_fifo_pkt #(
        .DATA_WIDTH(32), .DEPTH(16), .RAM_RD_LATENCY(2), .PACKET_MODE(1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_data(wr_data_a),
        .wr_last(wr_last_a), .wr_abort(wr_abort_a),
        .rd_ready(rd_ready_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
        .rd_last(rd_last_a), .written(written_a), .readable(readable_a),
        .afull(afull_a), .aempty(aempty_a), .pkt_ovf(pkt_ovf_a)
    );

    // ---------------- DUT B: DEPTH 12, latency 3, packet mode ----------------
    logic        wr_valid_b, wr_ready_b, wr_last_b, rd_ready_b, rd_valid_b, rd_last_b;
    logic        afull_b, aempty_b, pkt_ovf_b;
    logic [15:0] wr_data_b, rd_data_b;
    logic [3:0]  written_b, readable_b;
    logic        b_rand = 1'b0;

    accelbrot_com_ram_fifo_pkt #(
        .DATA_WIDTH(16), .DEPTH(12), .RAM_RD_LATENCY(3), .PACKET_MODE(1)
    ) dut_b (
        .clk(clk), .rstn(rstn), .flush(1'b0),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_data(wr_data_b),
        .wr_last(wr_last_b), .wr_abort(1'b0),
        .rd_ready(rd_ready_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .rd_last(rd_last_b), .written(written_b), .readable(readable_b),
        .afull(afull_b), .aempty(aempty_b), .pkt_ovf(pkt_ovf_b)
    );

    // ---------------- DUT C: DEPTH 8, latency 1, streaming mode ----------------
    logic       wr_valid_c, wr_ready_c, wr_last_c, wr_abort_c, rd_valid_c, rd_last_c;
    logic       afull_c, aempty_c, pkt_ovf_c;
    logic [7:0] wr_data_c, rd_data_c;
    logic [3:0] written_c, readable_c;

    accelbrot_com_ram_fifo_pkt #(
        .DATA_WIDTH(8), .DEPTH(8), .RAM_RD_LATENCY(1), .PACKET_MODE(0)
    ) dut_c (
        .clk(clk), .rstn(rstn), .flush(1'b0),
        .wr_valid(wr_valid_c), .wr_ready(wr_ready_c), .wr_data(wr_data_c),
        .wr_last(wr_last_c), .wr_abort(wr_abort_c),
        .rd_ready(1'b1), .rd_valid(rd_valid_c), .rd_data(rd_data_c),
        .rd_last(rd_last_c), .written(written_c), .readable(readable_c),
        .afull(afull_c), .aempty(aempty_c), .pkt_ovf(pkt_ovf_c)
    );

    // ---------------- scoreboards ----------------
    logic [32:0] exp_a[$], pend_a[$];
    logic [16:0] exp_b[$], pend_b[$];
    int          pops_a = 0, pops_b = 0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [32:0] hold_a, e_a;
    logic [16:0] hold_b, e_b;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_a) begin
                chk("a_hold_valid", 64'(rd_valid_a), 64'd1);
                chk("a_hold_data", 64'({rd_last_a, rd_data_a}), 64'(hold_a));
            end
            if (rd_valid_a && rd_ready_a) begin
                total++;
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected got=%0h", {rd_last_a, rd_data_a});
                end else begin
                    e_a = exp_a.pop_front();
                    pops_a++;
                    if ({rd_last_a, rd_data_a} !== e_a) begin
                        bad++;
                        $display("FAIL a_data got=%0h exp=%0h", {rd_last_a, rd_data_a}, e_a);
                    end
                end
            end
            stall_a = rd_valid_a && !rd_ready_a;
            hold_a  = {rd_last_a, rd_data_a};
        end else begin
            stall_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_b) begin
                chk("b_hold_valid", 64'(rd_valid_b), 64'd1);
                chk("b_hold_data", 64'({rd_last_b, rd_data_b}), 64'(hold_b));
            end
            if (rd_valid_b && rd_ready_b) begin
                total++;
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected got=%0h", {rd_last_b, rd_data_b});
                end else begin
                    e_b = exp_b.pop_front();
                    pops_b++;
                    if ({rd_last_b, rd_data_b} !== e_b) begin
                        bad++;
                        $display("FAIL b_data got=%0h exp=%0h", {rd_last_b, rd_data_b}, e_b);
                    end
                end
            end
            stall_b = rd_valid_b && !rd_ready_b;
            hold_b  = {rd_last_b, rd_data_b};
        end else begin
            stall_b = 1'b0;
        end
    end

    initial begin
        rd_ready_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready_b = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- drivers ----------------
    task automatic push_a(input logic [31:0] d, input logic last);
        int unsigned n = 0;
        wr_valid_a = 1'b1; wr_data_a = d; wr_last_a = last;
        while (!wr_ready_a && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!wr_ready_a) begin
            total++; bad++;
            $display("FAIL a_wr_wait got=0 exp=1");
        end else begin
            @(posedge clk);
            pend_a.push_back({last, d});
            if (last) begin
                foreach (pend_a[k]) exp_a.push_back(pend_a[k]);
                pend_a.delete();
            end
            #1;
        end
        wr_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] d, input logic last);
        int unsigned n = 0;
        wr_valid_b = 1'b1; wr_data_b = d; wr_last_b = last;
        while (!wr_ready_b && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!wr_ready_b) begin
            total++; bad++;
            $display("FAIL b_wr_wait got=0 exp=1");
        end else begin
            @(posedge clk);
            pend_b.push_back({last, d});
            if (last) begin
                foreach (pend_b[k]) exp_b.push_back(pend_b[k]);
                pend_b.delete();
            end
            #1;
        end
        wr_valid_b = 1'b0;
    endtask

    task automatic drain_a();
        int unsigned n = 0;
        while (exp_a.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("a_drain_left", 64'(exp_a.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int p0;

    initial begin
        rstn = 1'b0;
        flush_a = 0; wr_valid_a = 0; wr_last_a = 0; wr_abort_a = 0; wr_data_a = '0; rd_ready_a = 1;
        wr_valid_b = 0; wr_last_b = 0; wr_data_b = '0;
        wr_valid_c = 0; wr_last_c = 0; wr_abort_c = 0; wr_data_c = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", 64'(wr_ready_a), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid_a), 64'd0);
        chk("rst_written", 64'(written_a), 64'd0);
        chk("rst_readable", 64'(readable_a), 64'd0);
        chk("rst_afull", 64'(afull_a), 64'd0);
        chk("rst_aempty", 64'(aempty_a), 64'd1);
        chk("rst_pkt_ovf", 64'(pkt_ovf_a), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_wr_ready", 64'(wr_ready_a), 64'd1);

        // 3-word packet at edges 0..2, rd_valid after edge 5
        push_a(32'hA1, 1'b0);
        chk("p3_written0", 64'(written_a), 64'd1);
        chk("p3_readable0", 64'(readable_a), 64'd0);
        push_a(32'hA2, 1'b0);
        push_a(32'hA3, 1'b1);
        chk("p3_readable2", 64'(readable_a), 64'd3);
        chk("p3_valid_e2", 64'(rd_valid_a), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("p3_valid_e4", 64'(rd_valid_a), 64'd0);
        @(posedge clk); #1;
        chk("p3_valid_e5", 64'(rd_valid_a), 64'd1);
        drain_a();
        chk("p3_written_end", 64'(written_a), 64'd0);

        // back-to-back throughput: 8 single-word packets, 8 reads by edge 11
        p0 = pops_a;
        for (int i = 0; i < 8; i++) push_a(32'h100 + 32'(i), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("tput_pops", 64'(pops_a - p0), 64'd8);
        drain_a();

        // abort after 5 open words; prior committed packet survives
        rd_ready_a = 1'b0;
        push_a(32'hB0, 1'b0);
        push_a(32'hB1, 1'b1);
        for (int i = 0; i < 5; i++) push_a(32'hC0 + 32'(i), 1'b0);
        chk("ab_written_pre", 64'(written_a), 64'd7);
        chk("ab_readable_pre", 64'(readable_a), 64'd2);
        wr_valid_a = 1'b1; wr_data_a = 32'hDEAD; wr_last_a = 1'b1; wr_abort_a = 1'b1;
        @(posedge clk); #1;
        wr_valid_a = 1'b0; wr_abort_a = 1'b0; wr_last_a = 1'b0;
        pend_a.delete();
        chk("ab_written", 64'(written_a), 64'd2);
        chk("ab_readable", 64'(readable_a), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        rd_ready_a = 1'b1;
        drain_a();
        chk("ab_written_end", 64'(written_a), 64'd0);
        chk("ab_readable_end", 64'(readable_a), 64'd0);

        // 16 open words: full and overflow; abort clears
        for (int i = 0; i < 16; i++) begin
            push_a(32'h200 + 32'(i), 1'b0);
            if (i == 14) chk("ovf_pre15", 64'(pkt_ovf_a), 64'd0);
        end
        chk("ovf_wr_ready", 64'(wr_ready_a), 64'd0);
        chk("ovf_flag", 64'(pkt_ovf_a), 64'd1);
        chk("ovf_written", 64'(written_a), 64'd16);
        @(posedge clk); #1;
        chk("ovf_afull", 64'(afull_a), 64'd1);
        wr_abort_a = 1'b1;
        @(posedge clk); #1;
        wr_abort_a = 1'b0;
        pend_a.delete();
        chk("ovf_clr_flag", 64'(pkt_ovf_a), 64'd0);
        chk("ovf_clr_written", 64'(written_a), 64'd0);
        chk("ovf_clr_wr_ready", 64'(wr_ready_a), 64'd1);
        chk("ovf_clr_readable", 64'(readable_a), 64'd0);

        // fill 10 committed words, then flush with write and read active
        rd_ready_a = 1'b0;
        for (int i = 0; i < 10; i++) push_a(32'h300 + 32'(i), (i == 4) || (i == 9));
        chk("fl_written_pre", 64'(written_a), 64'd10);
        chk("fl_readable_pre", 64'(readable_a), 64'd10);
        repeat (4) @(posedge clk);
        #1;
        flush_a = 1'b1; wr_valid_a = 1'b1; wr_data_a = 32'hF00D; wr_last_a = 1'b1; rd_ready_a = 1'b1;
        @(posedge clk); #1;
        flush_a = 1'b0; wr_valid_a = 1'b0; wr_last_a = 1'b0;
        exp_a.delete();
        chk("fl_readable", 64'(readable_a), 64'd0);
        chk("fl_written", 64'(written_a), 64'd0);
        chk("fl_rd_valid", 64'(rd_valid_a), 64'd0);
        chk("fl_wr_ready0", 64'(wr_ready_a), 64'd0);
        @(posedge clk); #1;
        chk("fl_wr_ready1", 64'(wr_ready_a), 64'd1);
        chk("fl_aempty", 64'(aempty_a), 64'd1);
        repeat (4) @(posedge clk);
        #1;

        // streaming mode, latency 1: abort ignored, rd_valid after edge N+2
        wr_valid_c = 1'b1; wr_data_c = 8'h5A; wr_last_c = 1'b0; wr_abort_c = 1'b1;
        @(posedge clk); #1;
        wr_valid_c = 1'b0; wr_abort_c = 1'b0;
        chk("c_written", 64'(written_c), 64'd1);
        chk("c_readable", 64'(readable_c), 64'd1);
        @(posedge clk); #1;
        chk("c_valid_n1", 64'(rd_valid_c), 64'd0);
        @(posedge clk); #1;
        chk("c_valid_n2", 64'(rd_valid_c), 64'd1);
        chk("c_data", 64'(rd_data_c), 64'h5A);
        chk("c_last", 64'(rd_last_c), 64'd0);
        @(posedge clk); #1;
        chk("c_valid_n3", 64'(rd_valid_c), 64'd0);
        chk("c_written_end", 64'(written_c), 64'd0);
        chk("c_pkt_ovf", 64'(pkt_ovf_c), 64'd0);

        // DEPTH 12 stream of 100 words with random back-pressure
        b_rand = 1'b1;
        for (int i = 0; i < 100; i++)
            push_b(16'h5000 + 16'(i), (i % 7 == 2) || (i % 5 == 4) || (i == 99));
        begin
            int unsigned n = 0;
            while (exp_b.size() != 0 && n < 600) begin
                @(posedge clk); #1; n++;
            end
        end
        b_rand = 1'b0;
        chk("b_left", 64'(exp_b.size()), 64'd0);
        chk("b_pops", 64'(pops_b), 64'd100);
        @(posedge clk); #1;
        chk("b_written_end", 64'(written_b), 64'd0);

        // reset with committed and open data pending
        rd_ready_a = 1'b0;
        push_a(32'h400, 1'b0);
        push_a(32'h401, 1'b0);
        push_a(32'h402, 1'b1);
        push_a(32'h403, 1'b0);
        push_a(32'h404, 1'b0);
        rstn = 1'b0;
        exp_a.delete();
        pend_a.delete();
        #2;
        chk("mr_written", 64'(written_a), 64'd0);
        chk("mr_readable", 64'(readable_a), 64'd0);
        chk("mr_rd_valid", 64'(rd_valid_a), 64'd0);
        chk("mr_wr_ready", 64'(wr_ready_a), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rd_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("mr_wr_ready_rel", 64'(wr_ready_a), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("mr_readable_end", 64'(readable_a), 64'd0);
        chk("mr_rd_valid_end", 64'(rd_valid_a), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
